// File: rtl/ex_mem_skid.sv
// Execute-to-memory pipeline boundary: a 2-entry skid buffer (OUT + SKD) with a registered
// ready toward execute and rs1/rs2 forwarding from both held entries.
module ex_mem_skid #(
  parameter int XLEN = 32,
  parameter int MOPW = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ex_valid_i,
  input  logic            alu_stall_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_we_i,
  input  logic [MOPW-1:0] mem_op_i,
  output logic            ex_ready_o,
  input  logic            flush_i,
  output logic            mem_valid_o,
  input  logic            mem_ready_i,
  output logic [XLEN-1:0] mem_result_o,
  output logic [XLEN-1:0] mem_store_data_o,
  output logic [XLEN-1:0] mem_pc_o,
  output logic [4:0]      mem_rd_addr_o,
  output logic            mem_rd_we_o,
  output logic [MOPW-1:0] mem_op_o,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic            fwd_rs1_hit_o,
  output logic            fwd_rs2_hit_o,
  output logic [XLEN-1:0] fwd_rs1_data_o,
  output logic [XLEN-1:0] fwd_rs2_data_o,
  output logic [1:0]      occ_o
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd_addr;
    logic            rd_we;
    logic [MOPW-1:0] op;
  } entry_t;

  entry_t out_r, skd_r, out_n_s, skd_n_s, in_s;
  logic   out_v_r, skd_v_r, rdy_r;
  logic   out_v_n_s, skd_v_n_s;
  logic   push_s, pop_s;

  function automatic logic fwd_match(input logic v, input entry_t e, input logic [4:0] rs);
    return v & e.rd_we & (e.rd_addr != 5'd0) & (e.rd_addr == rs);
  endfunction

  assign in_s   = '{result: alu_result_i, store_data: store_data_i, pc: pc_i,
                    rd_addr: rd_addr_i, rd_we: rd_we_i, op: mem_op_i};
  assign push_s = ex_valid_i & ~alu_stall_i & rdy_r & ~flush_i;
  assign pop_s  = out_v_r & mem_ready_i;

  // Next-state of both entries; flush only clears valid bits, payloads are kept.
  always_comb begin
    out_n_s   = out_r;
    skd_n_s   = skd_r;
    out_v_n_s = out_v_r;
    skd_v_n_s = skd_v_r;
    if (flush_i) begin
      out_v_n_s = 1'b0;
      skd_v_n_s = 1'b0;
    end else begin
      case ({out_v_r, skd_v_r})
        2'b00: begin
          if (push_s) begin
            out_n_s   = in_s;
            out_v_n_s = 1'b1;
          end else begin
            out_v_n_s = 1'b0;
          end
        end
        2'b10: begin
          if (push_s && pop_s) begin
            out_n_s = in_s;
          end else if (push_s) begin
            skd_n_s   = in_s;
            skd_v_n_s = 1'b1;
          end else if (pop_s) begin
            out_v_n_s = 1'b0;
          end else begin
            out_v_n_s = 1'b1;
          end
        end
        2'b11: begin
          if (pop_s) begin
            out_n_s   = skd_r;
            skd_v_n_s = 1'b0;
          end else begin
            skd_v_n_s = 1'b1;
          end
        end
        default: begin
          // SKD valid without OUT breaks the invariant; drop the orphan entry.
          skd_v_n_s = 1'b0;
        end
      endcase
    end
  end

  // State registers; ready is registered from the next skid state so it never sees mem_ready_i combinationally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_r   <= '0;
      skd_r   <= '0;
      out_v_r <= 1'b0;
      skd_v_r <= 1'b0;
      rdy_r   <= 1'b1;
    end else begin
      out_r   <= out_n_s;
      skd_r   <= skd_n_s;
      out_v_r <= out_v_n_s;
      skd_v_r <= skd_v_n_s;
      rdy_r   <= ~skd_v_n_s;
    end
  end

  assign ex_ready_o       = rdy_r;
  assign mem_valid_o      = out_v_r;
  assign mem_result_o     = out_r.result;
  assign mem_store_data_o = out_r.store_data;
  assign mem_pc_o         = out_r.pc;
  assign mem_rd_addr_o    = out_r.rd_addr;
  assign mem_rd_we_o      = out_r.rd_we;
  assign mem_op_o         = out_r.op;
  assign occ_o            = {1'b0, out_v_r} + {1'b0, skd_v_r};

  // Forwarding: SKD holds the younger result and wins over OUT.
  always_comb begin
    fwd_rs1_hit_o  = 1'b0;
    fwd_rs1_data_o = '0;
    fwd_rs2_hit_o  = 1'b0;
    fwd_rs2_data_o = '0;
    if (fwd_match(skd_v_r, skd_r, rs1_addr_i)) begin
      fwd_rs1_hit_o  = 1'b1;
      fwd_rs1_data_o = skd_r.result;
    end else if (fwd_match(out_v_r, out_r, rs1_addr_i)) begin
      fwd_rs1_hit_o  = 1'b1;
      fwd_rs1_data_o = out_r.result;
    end else begin
      fwd_rs1_hit_o  = 1'b0;
    end
    if (fwd_match(skd_v_r, skd_r, rs2_addr_i)) begin
      fwd_rs2_hit_o  = 1'b1;
      fwd_rs2_data_o = skd_r.result;
    end else if (fwd_match(out_v_r, out_r, rs2_addr_i)) begin
      fwd_rs2_hit_o  = 1'b1;
      fwd_rs2_data_o = out_r.result;
    end else begin
      fwd_rs2_hit_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed self-checking bench for ex_mem_skid: streaming, backpressure, stall, flush,
// forwarding and asynchronous reset, with hand-computed expectations.
module tb_ex_mem_skid;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic        ex_valid, alu_stall, rd_we, ex_ready, flush, mem_valid, mem_ready;
  logic [31:0] alu_result, store_data, pc;
  logic [4:0]  rd_addr, rs1_addr, rs2_addr, mem_rd_addr;
  logic [3:0]  mem_op, mem_op_out;
  logic [31:0] mem_result, mem_store_data, mem_pc, fwd_rs1_data, fwd_rs2_data;
  logic        mem_rd_we, fwd_rs1_hit, fwd_rs2_hit;
  logic [1:0]  occ;
  int          checks = 0;
  int          failures = 0;

  ex_mem_skid #(.XLEN(32), .MOPW(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .ex_valid_i(ex_valid), .alu_stall_i(alu_stall),
    .alu_result_i(alu_result), .store_data_i(store_data), .pc_i(pc), .rd_addr_i(rd_addr),
    .rd_we_i(rd_we), .mem_op_i(mem_op), .ex_ready_o(ex_ready), .flush_i(flush),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_result_o(mem_result),
    .mem_store_data_o(mem_store_data), .mem_pc_o(mem_pc), .mem_rd_addr_o(mem_rd_addr),
    .mem_rd_we_o(mem_rd_we), .mem_op_o(mem_op_out), .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .fwd_rs1_hit_o(fwd_rs1_hit), .fwd_rs2_hit_o(fwd_rs2_hit), .fwd_rs1_data_o(fwd_rs1_data),
    .fwd_rs2_data_o(fwd_rs2_data), .occ_o(occ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] rd, input logic we);
    ex_valid   = v;
    alu_result = r;
    store_data = ~r;
    pc         = r + 32'h100;
    rd_addr    = rd;
    rd_we      = we;
    mem_op     = r[3:0];
  endtask

  initial begin
    rst_ni = 1'b0; alu_stall = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    #12;
    check("rst_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_occ",   {30'd0, occ}, 32'd0);
    check("rst_ready", {31'd0, ex_ready}, 32'd1);
    check("rst_result", mem_result, 32'd0);
    check("rst_pc", mem_pc, 32'd0);
    check("rst_fwd", {30'd0, fwd_rs1_hit, fwd_rs2_hit}, 32'd0);
    tick();
    rst_ni = 1'b1;

    // Streaming with mem_ready held high.
    mem_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, i, 5'd1, 1'b1);
      tick();
      check("stream_result", mem_result, i);
      check("stream_valid", {31'd0, mem_valid}, 32'd1);
      check("stream_occ", {30'd0, occ}, 32'd1);
      check("stream_ready", {31'd0, ex_ready}, 32'd1);
    end
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    check("stream_drain_valid", {31'd0, mem_valid}, 32'd0);

    // Backpressure: A then B with mem_ready low.
    mem_ready = 1'b0;
    drive(1'b1, 32'hA, 5'd2, 1'b1);
    tick();
    check("bp_first_result", mem_result, 32'hA);
    check("bp_first_ready", {31'd0, ex_ready}, 32'd1);
    drive(1'b1, 32'hB, 5'd3, 1'b1);
    tick();
    check("bp_occ2", {30'd0, occ}, 32'd2);
    check("bp_ready_low", {31'd0, ex_ready}, 32'd0);
    check("bp_hold_result", mem_result, 32'hA);
    drive(1'b1, 32'hC, 5'd4, 1'b1);
    tick();
    check("bp_stable_result", mem_result, 32'hA);
    check("bp_stable_pc", mem_pc, 32'h10A);
    check("bp_stable_store", mem_store_data, 32'hFFFF_FFF5);
    check("bp_stable_rd", {27'd0, mem_rd_addr}, 32'd2);
    check("bp_stable_op", {28'd0, mem_op_out}, 32'hA);
    check("bp_occ_still2", {30'd0, occ}, 32'd2);
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    mem_ready = 1'b1;
    tick();
    check("bp_second_result", mem_result, 32'hB);
    check("bp_second_occ", {30'd0, occ}, 32'd1);
    check("bp_ready_back", {31'd0, ex_ready}, 32'd1);
    tick();
    check("bp_empty", {30'd0, occ}, 32'd0);

    // Multi-cycle ALU stall blocks push.
    drive(1'b1, 32'h55, 5'd6, 1'b1);
    alu_stall = 1'b1;
    for (int i = 0; i < 33; i++) begin
      tick();
      check("stall_no_push", {31'd0, mem_valid}, 32'd0);
    end
    alu_stall = 1'b0;
    drive(1'b1, 32'hDEADBEEF, 5'd6, 1'b1);
    tick();
    check("stall_result", mem_result, 32'hDEADBEEF);
    check("stall_valid", {31'd0, mem_valid}, 32'd1);
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    check("stall_single", {31'd0, mem_valid}, 32'd0);

    // Flush with both entries full and a valid input offered.
    mem_ready = 1'b0;
    drive(1'b1, 32'h31, 5'd7, 1'b1);
    tick();
    drive(1'b1, 32'h32, 5'd7, 1'b1);
    tick();
    check("flush_pre_occ", {30'd0, occ}, 32'd2);
    drive(1'b1, 32'h33, 5'd7, 1'b1);
    flush = 1'b1;
    tick();
    check("flush_occ", {30'd0, occ}, 32'd0);
    check("flush_valid", {31'd0, mem_valid}, 32'd0);
    check("flush_ready", {31'd0, ex_ready}, 32'd1);
    check("flush_payload_kept", mem_result, 32'h31);
    // Flush with one entry and ready high: the offered input must still be dropped.
    flush = 1'b0;
    drive(1'b1, 32'h34, 5'd7, 1'b1);
    tick();
    drive(1'b1, 32'h35, 5'd7, 1'b1);
    flush = 1'b1;
    tick();
    check("flush1_occ", {30'd0, occ}, 32'd0);
    check("flush1_payload", mem_result, 32'h34);
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    check("flush_not_captured", {31'd0, mem_valid}, 32'd0);

    // Forwarding: OUT only, then SKD priority.
    drive(1'b1, 32'h11, 5'd5, 1'b1);
    tick();
    rs1_addr = 5'd5; rs2_addr = 5'd7;
    #1;
    check("fwd_out_hit", {31'd0, fwd_rs1_hit}, 32'd1);
    check("fwd_out_data", fwd_rs1_data, 32'h11);
    check("fwd_miss_hit", {31'd0, fwd_rs2_hit}, 32'd0);
    check("fwd_miss_data", fwd_rs2_data, 32'h0);
    drive(1'b1, 32'h22, 5'd5, 1'b1);
    tick();
    rs2_addr = 5'd5;
    #1;
    check("fwd_skd_rs1_data", fwd_rs1_data, 32'h22);
    check("fwd_skd_rs2_hit", {31'd0, fwd_rs2_hit}, 32'd1);
    check("fwd_skd_rs2_data", fwd_rs2_data, 32'h22);
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fwd_after_flush", {31'd0, fwd_rs1_hit}, 32'd0);
    drive(1'b1, 32'h44, 5'd0, 1'b1);
    tick();
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    check("fwd_x0_hit", {30'd0, fwd_rs1_hit, fwd_rs2_hit}, 32'd0);
    check("fwd_x0_data", fwd_rs2_data, 32'h0);
    drive(1'b1, 32'h55, 5'd9, 1'b0);
    tick();
    rs1_addr = 5'd9;
    #1;
    check("fwd_nowe_hit", {31'd0, fwd_rs1_hit}, 32'd0);
    check("fwd_full_occ", {30'd0, occ}, 32'd2);
    drive(1'b0, 32'h0, 5'd0, 1'b0);

    // Asynchronous reset between edges with both entries held.
    #1;
    rst_ni = 1'b0;
    #1;
    check("arst_valid", {31'd0, mem_valid}, 32'd0);
    check("arst_occ", {30'd0, occ}, 32'd0);
    check("arst_ready", {31'd0, ex_ready}, 32'd1);
    check("arst_result", mem_result, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("post_rst_valid", {31'd0, mem_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
